// File: rtl/cic_decim_scheduler.sv
// cic_decim_scheduler: round-robin sharing of one CIC decimator across N_CH channels with drain/flush rate changes.
// Optional stall statistics (o_stall_cnt, i_stats_clr) are enabled by defining CIC_SCHED_STATS_EN.
module cic_decim_scheduler #(
    parameter int N_CH         = 4,
    parameter int DATA_W       = 24,
    parameter int RATE_W       = 8,
    parameter int DEFAULT_RATE = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_CH-1:0]          i_ch_valid,
    input  logic [N_CH*DATA_W-1:0]   i_ch_data,
    output logic [N_CH-1:0]          o_ch_ready,
    output logic                     o_cic_valid,
    output logic [DATA_W-1:0]        o_cic_data,
    output logic [$clog2(N_CH)-1:0]  o_cic_ch,
    output logic                     o_cic_dump,
    input  logic                     i_cic_ready,
    output logic                     o_cic_flush,
    input  logic [RATE_W-1:0]        i_rate,
    input  logic                     i_rate_wr,
    output logic                     o_busy
`ifdef CIC_SCHED_STATS_EN
    ,
    input  logic                     i_stats_clr,
    output logic [15:0]              o_stall_cnt
`endif
);
    localparam int CW = $clog2(N_CH);
    typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;
    state_t            state;
    logic [RATE_W-1:0] rate, pending, wr_rate;
    logic [RATE_W-1:0] cnt [N_CH];
    logic [CW-1:0]     ptr, gnt;
    logic              found, load_ok, accept, last_cnt;

    assign wr_rate  = (i_rate == '0) ? RATE_W'(1) : i_rate;
    assign load_ok  = !o_cic_valid || i_cic_ready;
    assign accept   = i_rst_n && state == RUN && load_ok && found;
    assign o_ch_ready = accept ? N_CH'(1) << gnt : '0;
    assign last_cnt = cnt[gnt] == rate - 1'b1;

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!found && i_ch_valid[(int'(ptr) + i) % N_CH]) begin
                found = 1'b1;
                gnt   = CW'((int'(ptr) + i) % N_CH);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= RUN;
            rate        <= RATE_W'(DEFAULT_RATE);
            pending     <= RATE_W'(DEFAULT_RATE);
            ptr         <= CW'(N_CH - 1);
            o_cic_valid <= 1'b0;
            o_cic_data  <= '0;
            o_cic_ch    <= '0;
            o_cic_dump  <= 1'b0;
            o_cic_flush <= 1'b0;
            o_busy      <= 1'b0;
            for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
        end else begin
            if (load_ok) begin
                o_cic_valid <= accept;
                o_cic_dump  <= accept && last_cnt;
            end
            if (accept) begin
                o_cic_data <= i_ch_data[gnt*DATA_W +: DATA_W];
                o_cic_ch   <= gnt;
                ptr        <= gnt;
                cnt[gnt]   <= last_cnt ? '0 : cnt[gnt] + 1'b1;
            end
            if (i_rate_wr) pending <= wr_rate;
            case (state)
                RUN:   if (i_rate_wr) state <= DRAIN;
                DRAIN: if (load_ok) state <= FLUSH;
                default: begin
                    // a write landing in the flush cycle is the last one, so it wins over pending
                    state <= RUN;
                    rate  <= i_rate_wr ? wr_rate : pending;
                    ptr   <= CW'(N_CH - 1);
                    for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
                end
            endcase
            o_cic_flush <= state == DRAIN && load_ok;
            o_busy      <= (state == RUN && i_rate_wr) || state == DRAIN;
        end
    end

`ifdef CIC_SCHED_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_stats_clr) o_stall_cnt <= '0;
        else if (o_cic_valid && !i_cic_ready && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 1'b1;
    end
`endif
endmodule
